// File: rtl/serial_adder_pkg.sv
// Shared types and uio bit map for the bit-serial adder controller.
// No logic; latency and backpressure not applicable.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int LD_A  = 0;
    localparam int LD_B  = 1;
    localparam int START = 2;
    localparam int BUSY  = 3;
    localparam int DONE  = 4;
    localparam int COUT  = 5;

    localparam logic [7:0] UIO_OE_MASK = 8'h38;

endpackage

// File: rtl/tt_um_serial_adder_ctrl_ha_cell.sv
// One-bit half adder. Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module ha_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule

// File: rtl/tt_um_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder with load/start/busy/done handshake on uio pins.
// Latency: done rises WIDTH enabled edges after start; ena=0 stalls everything, loads/start ignored while busy.
module tt_um_serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state,   w_state_nxt;
    logic [WIDTH-1:0]   r_op_a,    w_op_a_nxt;
    logic [WIDTH-1:0]   r_op_b,    w_op_b_nxt;
    logic [WIDTH-1:0]   r_sum,     w_sum_nxt;
    logic [WIDTH-1:0]   r_result,  w_result_nxt;
    logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic               r_carry,   w_carry_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_done,    w_done_nxt;
    logic               r_cout,    w_cout_nxt;

    logic               w_ld_a, w_ld_b, w_start;
    logic               w_s1, w_c1, w_s, w_c2;
    logic [WIDTH-1:0]   w_sum_shift;
    logic               w_unused;

    assign w_ld_a  = uio_in[LD_A];
    assign w_ld_b  = uio_in[LD_B];
    assign w_start = uio_in[START];
    assign w_unused = &{1'b0, uio_in[7:3], ui_in};

    // Two half adders chained into one full-add step on the current bit.
    ha_cell u_ha1 (
        .i_a     (r_op_a[r_bit_cnt]),
        .i_b     (r_op_b[r_bit_cnt]),
        .o_sum   (w_s1),
        .o_carry (w_c1)
    );

    ha_cell u_ha2 (
        .i_a     (w_s1),
        .i_b     (r_carry),
        .o_sum   (w_s),
        .o_carry (w_c2)
    );

    assign w_sum_shift = {w_s, r_sum[WIDTH-1:1]};

    always_comb begin
        w_state_nxt   = r_state;
        w_op_a_nxt    = r_op_a;
        w_op_b_nxt    = r_op_b;
        w_sum_nxt     = r_sum;
        w_result_nxt  = r_result;
        w_bit_cnt_nxt = r_bit_cnt;
        w_carry_nxt   = r_carry;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_cout_nxt    = r_cout;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_ld_a) w_op_a_nxt = ui_in[WIDTH-1:0];
                if (w_ld_b) w_op_b_nxt = ui_in[WIDTH-1:0];
                if (w_ld_a || w_ld_b) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (w_start) begin
                    w_state_nxt   = S_RUN;
                    w_bit_cnt_nxt = '0;
                    w_carry_nxt   = 1'b0;
                    w_sum_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                end
            end
            S_RUN: begin
                w_carry_nxt = w_c1 | w_c2;
                w_sum_nxt   = w_sum_shift;
                if (r_bit_cnt == LAST_BIT) begin
                    w_result_nxt = w_sum_shift;
                    w_cout_nxt   = w_c1 | w_c2;
                    w_state_nxt  = S_DONE;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_sum     <= '0;
            r_result  <= '0;
            r_bit_cnt <= '0;
            r_carry   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cout    <= 1'b0;
        end else if (ena) begin
            r_state   <= w_state_nxt;
            r_op_a    <= w_op_a_nxt;
            r_op_b    <= w_op_b_nxt;
            r_sum     <= w_sum_nxt;
            r_result  <= w_result_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_carry   <= w_carry_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_cout    <= w_cout_nxt;
        end
    end

    assign uo_out  = 8'(r_result);
    assign uio_out = {2'b00, r_cout, r_done, r_busy, 3'b000};
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_serial_adder_ctrl.sv
// Scoreboard bench for the serial adder: stimulus pushes expected results, monitor checks on done rise.
module tb_tt_um_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    tt_um_serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    wire w_busy = uio_out[3];
    wire w_done = uio_out[4];
    wire w_cout = uio_out[5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: latency from busy rise to done rise, plus result/cout on done rise.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        check("busy_done_exclusive", int'(w_busy & w_done), 0);
        if (w_busy && !prev_busy) start_cyc = cyc;
        if (w_done && !prev_done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result", int'(uo_out), int'(e.sum));
                check("cout", int'(w_cout), int'(e.cout));
                check("latency", cyc - start_cyc, e.lat);
            end
        end
        prev_busy = w_busy;
        prev_done = w_done;
    end

    task automatic drive(input logic [7:0] ctl, input logic [7:0] dat);
        @(negedge clk);
        uio_in = ctl;
        ui_in  = dat;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!w_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!w_done) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] s, input logic c, input string name);
        drive(8'h01, a);
        drive(8'h02, b);
        exp_q.push_back('{sum: s, cout: c, lat: 8});
        drive(8'h04, 8'h00);
        idle_bus();
        wait_done(name);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_uo_out", int'(uo_out), 0);
        check("rst_uio_out", int'(uio_out), 0);
        check("uio_oe", int'(uio_oe), 8'h38);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        run_op(8'h3C, 8'h05, 8'h41, 1'b0, "t1");
        run_op(8'hFF, 8'h01, 8'h00, 1'b1, "t2");

        // Loads and start during RUN are ignored.
        drive(8'h01, 8'h80);
        drive(8'h02, 8'h80);
        exp_q.push_back('{sum: 8'h00, cout: 1'b1, lat: 8});
        drive(8'h04, 8'h00);
        idle_bus();
        drive(8'h05, 8'h11);
        idle_bus();
        check("t3_busy_mid", int'(w_busy), 1);
        wait_done("t3");
        exp_q.push_back('{sum: 8'h00, cout: 1'b1, lat: 8});
        drive(8'h04, 8'h00);
        idle_bus();
        wait_done("t3_rerun");

        // ena low mid-RUN stretches completion by the stall length.
        drive(8'h01, 8'h0F);
        drive(8'h02, 8'h01);
        exp_q.push_back('{sum: 8'h10, cout: 1'b0, lat: 11});
        drive(8'h04, 8'h00);
        idle_bus();
        @(negedge clk);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_busy_stall", int'(w_busy), 1);
        ena = 1'b1;
        wait_done("t5");

        // In DONE, start plus load: the load wins and done drops.
        drive(8'h06, 8'h02);
        idle_bus();
        check("t6_done_clr", int'(w_done), 0);
        check("t6_busy", int'(w_busy), 0);
        check("t6_uo_held", int'(uo_out), 8'h10);
        exp_q.push_back('{sum: 8'h11, cout: 1'b0, lat: 8});
        drive(8'h04, 8'h00);
        idle_bus();
        wait_done("t6");

        // Reset partway through an add aborts it with no done pulse.
        drive(8'h01, 8'h55);
        drive(8'h02, 8'hAA);
        drive(8'h04, 8'h00);
        idle_bus();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_uo_out", int'(uo_out), 0);
        check("t4_uio_out", int'(uio_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t4_idle_busy", int'(w_busy), 0);
        check("t4_idle_done", int'(w_done), 0);

        // Start with a load in IDLE is ignored; both loads in one cycle share the value.
        drive(8'h07, 8'h7F);
        idle_bus();
        check("ld_start_ignored", int'(w_busy), 0);
        exp_q.push_back('{sum: 8'hFE, cout: 1'b0, lat: 8});
        drive(8'h04, 8'h00);
        idle_bus();
        wait_done("both_ld");

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
